// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = stream source / memory side, slave = loader.
interface imem_loader_if #(
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (
    output in_valid,
    output in_byte,
    input  in_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  modport slave (
    input  in_valid,
    input  in_byte,
    output in_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs an MSB-first byte stream into
// 32-bit words, writes them to sequential addresses, XOR checksum.
module imem_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [ADDR_W:0] num_words,
  imem_loader_if.slave  bus,
  output logic          busy,
  output logic          done,
  output logic [31:0]   checksum
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE
  } state_t;

  localparam logic [ADDR_W:0] MAX_N =
    (ADDR_W+1)'(DEPTH);

  state_t          state;
  logic [ADDR_W:0] idx;
  logic [ADDR_W:0] count;
  logic [1:0]      cnt;
  logic [31:0]     word;

  logic            accept;
  logic [31:0]     word_nx;
  logic [ADDR_W:0] idx_nx;
  logic [ADDR_W:0] n_clamp;
  logic            n_zero;

  assign accept  = bus.in_valid & bus.in_ready;
  assign word_nx = {word[23:0], bus.in_byte};
  assign idx_nx  = idx + 1'b1;
  // Oversized requests are clipped so wr_addr stays in range.
  assign n_clamp = (num_words > MAX_N) ? MAX_N
                                       : num_words;
  assign n_zero  = (n_clamp == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      idx          <= '0;
      count        <= '0;
      cnt          <= '0;
      word         <= '0;
      checksum     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      bus.in_ready <= 1'b0;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            checksum <= '0;
            idx      <= '0;
            cnt      <= '0;
            word     <= '0;
            count    <= n_clamp;
            unique case (1'b1)
              n_zero: begin
                state        <= DONE;
                busy         <= 1'b0;
                done         <= 1'b1;
                bus.in_ready <= 1'b0;
              end
              !n_zero: begin
                state        <= LOAD;
                busy         <= 1'b1;
                done         <= 1'b0;
                bus.in_ready <= 1'b1;
              end
            endcase
          end
        end
        LOAD: begin
          if (accept) begin
            word <= word_nx;
            cnt  <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              state        <= WRITE;
              bus.in_ready <= 1'b0;
              bus.wr_en    <= 1'b1;
              bus.wr_addr  <= idx[ADDR_W-1:0];
              bus.wr_data  <= word_nx;
            end
          end
        end
        WRITE: begin
          bus.wr_en <= 1'b0;
          checksum  <= checksum ^ bus.wr_data;
          idx       <= idx_nx;
          if (idx_nx == count) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state        <= LOAD;
            bus.in_ready <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by
// the stimulus and popped by a negedge monitor on each wr_en.
module tb_imem_loader;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic            clk;
  logic            rst;
  logic            start;
  logic [ADDR_W:0] num_words;
  logic            busy;
  logic            done;
  logic [31:0]     checksum;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num_words(num_words),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .checksum (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wcount = 0;
  logic [ADDR_W+31:0] exp_q[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wcount++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexp_write act=%h/%h exp=none",
                 bus.wr_addr, bus.wr_data);
      end else begin
        logic [ADDR_W+31:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.wr_addr),
            32'(e[ADDR_W+31:32]));
        chk("wr_data", bus.wr_data, e[31:0]);
      end
    end
  end

  task automatic push_exp(input int a, input logic [31:0] d);
    logic [ADDR_W-1:0] aa;
    aa = ADDR_W'(a);
    exp_q.push_back({aa, d});
  endtask

  task automatic do_start(input int n);
    @(posedge clk);
    #1;
    start     = 1'b1;
    num_words = (ADDR_W+1)'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1)
      chk("byte_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w,
                           input bit gaps);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8]);
      if (gaps && i < 3) begin
        @(negedge clk);
        chk("rdy_in_gap", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
      end
    end
    chk("wr_latency", 32'(bus.wr_en), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done", 32'(done), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x;
    int w0;
    rst          = 1'b0;
    start        = 1'b0;
    num_words    = '0;
    bus.in_valid = 1'b0;
    bus.in_byte  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst_wr_data", bus.wr_data, 32'd0);
    chk("rst_checksum", checksum, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy), 32'd0);

    // single word, back-to-back bytes
    w0 = wcount;
    push_exp(0, 32'hE3A01005);
    do_start(1);
    chk("load_busy", 32'(busy), 32'd1);
    send_word(32'hE3A01005, 1'b0);
    wait_done(20);
    chk("cs_one", checksum, 32'hE3A01005);
    chk("nw_one", 32'(wcount - w0), 32'd1);

    // two words
    w0 = wcount;
    push_exp(0, 32'h11111111);
    push_exp(1, 32'h22222222);
    do_start(2);
    send_word(32'h11111111, 1'b0);
    chk("not_done_mid", 32'(done), 32'd0);
    send_word(32'h22222222, 1'b0);
    wait_done(20);
    chk("cs_two", checksum, 32'h33333333);
    chk("nw_two", 32'(wcount - w0), 32'd2);

    // bubbles between bytes
    push_exp(0, 32'hE3A01005);
    do_start(1);
    send_word(32'hE3A01005, 1'b1);
    wait_done(20);
    chk("cs_gaps", checksum, 32'hE3A01005);

    // reset mid-word discards partial bytes
    w0 = wcount;
    do_start(1);
    send_byte(8'hDE);
    send_byte(8'hAD);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    chk("mid_rst_data", bus.wr_data, 32'd0);
    chk("mid_rst_cs", checksum, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_idle", 32'({busy, done}), 32'd0);
    chk("nw_rst", 32'(wcount - w0), 32'd0);
    push_exp(0, 32'hAABBCCDD);
    do_start(1);
    send_word(32'hAABBCCDD, 1'b0);
    wait_done(20);
    chk("cs_after_rst", checksum, 32'hAABBCCDD);

    // zero-length load
    w0 = wcount;
    do_start(0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    chk("zero_cs", checksum, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("nw_zero", 32'(wcount - w0), 32'd0);

    // oversized request clips to DEPTH
    w0 = wcount;
    x  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      push_exp(i, 32'hC0DE0000 | 32'(i * 7));
      x ^= 32'hC0DE0000 | 32'(i * 7);
    end
    do_start(40);
    for (int i = 0; i < DEPTH; i++)
      send_word(32'hC0DE0000 | 32'(i * 7), 1'b0);
    wait_done(20);
    chk("nw_clip", 32'(wcount - w0), 32'd32);
    chk("cs_clip", checksum, x);
    chk("hold_addr", 32'(bus.wr_addr), 32'd31);
    chk("hold_data", bus.wr_data, 32'hC0DE00D9);
    chk("ready_done", 32'(bus.in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("cs_stable", checksum, x);

    // start during LOAD is ignored
    w0 = wcount;
    push_exp(0, 32'h0F0F0F0F);
    push_exp(1, 32'h12345678);
    do_start(2);
    send_byte(8'h0F);
    send_byte(8'h0F);
    start     = 1'b1;
    num_words = 6'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    send_byte(8'h0F);
    send_byte(8'h0F);
    chk("ign_lat", 32'(bus.wr_en), 32'd1);
    send_word(32'h12345678, 1'b0);
    wait_done(20);
    chk("nw_ign", 32'(wcount - w0), 32'd2);
    chk("cs_ign", checksum, 32'h1D3B5977);

    repeat (2) @(posedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
